// File: rtl/ucak_coklu_kapi.sv
// Multi-gate aircraft boarding controller: admits/rejects passengers from
// KAPI gates, then approves takeoff or cancels at the end of the window.
module ucak_coklu_kapi #(
    parameter  int KAPI      = 2,
    parameter  int KAPASITE  = 40,
    parameter  int MIN_YOLCU = 20,
    parameter  int SURE      = 50,
    parameter  int RED_W     = 8,
    localparam int BW        = $clog2(KAPASITE + 1)
) (
    input  logic             saat,
    input  logic             reset,
    input  logic             basla,
    input  logic [KAPI-1:0]  o_yolcu,
    input  logic [KAPI-1:0]  g_kimlik,
    output logic             kalkis,
    output logic             bitti,
    output logic [BW-1:0]    binen,
    output logic [RED_W-1:0] reddedilen,
    output logic             dolu
);

    localparam int TW   = $clog2(SURE + 1);
    localparam int RMAX = (1 << RED_W) - 1;

    typedef enum logic [1:0] {
        BEKLE,
        BINIS,
        KALKIS,
        IPTAL
    } durum_t;

    durum_t           r_durum;
    durum_t           w_durum;
    logic [BW-1:0]    r_binen;
    logic [BW-1:0]    w_binen;
    logic [RED_W-1:0] r_red;
    logic [RED_W-1:0] w_red;
    logic [TW-1:0]    r_sayac;
    logic [TW-1:0]    w_sayac;
    logic             r_kalkis;
    logic             w_kalkis;
    logic             r_bitti;
    logic             w_bitti;

    int               w_kabul;
    int               w_ret;
    int               w_red_top;
    logic [BW-1:0]    w_binen_art;
    logic [RED_W-1:0] w_red_art;
    logic [TW-1:0]    w_sayac_art;
    logic             w_son;

    // Lower-index gates see the remaining seats first; full-refused
    // valid passengers fall through without being counted anywhere.
    always_comb begin
        w_kabul = 0;
        w_ret   = 0;
        for (int i = 0; i < KAPI; i++) begin
            if (o_yolcu[i]) begin
                if (g_kimlik[i]) begin
                    if (int'(r_binen) + w_kabul < KAPASITE) begin
                        w_kabul = w_kabul + 1;
                    end
                end else begin
                    w_ret = w_ret + 1;
                end
            end
        end
    end

    always_comb begin
        w_binen_art = BW'(int'(r_binen) + w_kabul);
        w_red_top   = int'(r_red) + w_ret;
        w_red_art   = (w_red_top > RMAX) ? RED_W'(RMAX)
                                         : RED_W'(w_red_top);
        w_sayac_art = r_sayac + TW'(1);
        w_son       = (w_binen_art == BW'(KAPASITE))
                   || (w_sayac_art == TW'(SURE));
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            r_durum  <= BEKLE;
            r_binen  <= '0;
            r_red    <= '0;
            r_sayac  <= '0;
            r_kalkis <= 1'b0;
            r_bitti  <= 1'b0;
        end else begin
            r_durum  <= w_durum;
            r_binen  <= w_binen;
            r_red    <= w_red;
            r_sayac  <= w_sayac;
            r_kalkis <= w_kalkis;
            r_bitti  <= w_bitti;
        end
    end

    always_comb begin
        w_durum  = r_durum;
        w_binen  = r_binen;
        w_red    = r_red;
        w_sayac  = r_sayac;
        w_kalkis = r_kalkis;
        w_bitti  = r_bitti;
        unique case (r_durum)
            BEKLE: begin
                w_bitti = 1'b0;
                if (basla) begin
                    w_durum  = BINIS;
                    w_binen  = '0;
                    w_red    = '0;
                    w_sayac  = '0;
                    w_kalkis = 1'b0;
                end
            end
            BINIS: begin
                if (basla) begin
                    w_binen = w_binen_art;
                    w_red   = w_red_art;
                    w_sayac = w_sayac_art;
                    if (w_son) begin
                        w_bitti = 1'b1;
                        if (w_binen_art >= BW'(MIN_YOLCU)) begin
                            w_durum  = KALKIS;
                            w_kalkis = 1'b1;
                        end else begin
                            w_durum  = IPTAL;
                            w_kalkis = 1'b0;
                        end
                    end
                end
            end
            KALKIS, IPTAL: begin
                if (!basla) begin
                    w_durum = BEKLE;
                    w_bitti = 1'b0;
                end
            end
            default: begin
                w_durum = BEKLE;
            end
        endcase
    end

    assign kalkis     = r_kalkis;
    assign bitti      = r_bitti;
    assign binen      = r_binen;
    assign reddedilen = r_red;
    assign dolu       = (r_binen == BW'(KAPASITE));

endmodule

// File: doc/ucak_coklu_kapi.md
Name: ucak_coklu_kapi

Overview:
- Parametrised successor of the single-gate aircraft boarding controller: N boarding gates feed one aircraft with a configurable seat count, minimum-load threshold and boarding window.
- Each gate presents a passenger-present / valid-ID pair every cycle. The block admits, rejects or ignores each passenger, then decides takeoff (kalkis) or cancellation at the end of the window.
- Sits between the gate sensor logic and the flight-status display/registers.

Parameters:
- KAPI, 2, number of boarding gates (1..8).
- KAPASITE, 40, seat count; the boarded count never exceeds this.
- MIN_YOLCU, 20, minimum boarded passengers required for takeoff (1..KAPASITE).
- SURE, 50, boarding window length in active (non-paused) boarding cycles.
- RED_W, 8, width of the saturating rejected-passenger counter.

Ports:
- saat  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- basla  input  1  session start / run-enable; 0 during boarding pauses the session.
- o_yolcu  input  KAPI  bit i = passenger present at gate i this cycle.
- g_kimlik  input  KAPI  bit i = passenger at gate i holds a valid ID.
- kalkis  output  1  takeoff approved (registered).
- bitti  output  1  session finished (registered).
- binen  output  clog2(KAPASITE+1)  passengers boarded this session.
- reddedilen  output  RED_W  invalid-ID passengers this session, saturating at 2^RED_W-1.
- dolu  output  1  high while binen == KAPASITE.

Behaviour:
- Clock and reset: one clock (saat); reset is synchronous and active-high. On reset: state BEKLE, kalkis=0, bitti=0, binen=0, reddedilen=0, dolu=0, window timer=0.
- Reset has priority over every other input, including mid-session.
- States: BEKLE (idle), BINIS (boarding), KALKIS (done, approved), IPTAL (done, cancelled).
- BEKLE: when basla=1, go to BINIS on the next edge and clear binen, reddedilen, timer and kalkis. When basla=0, hold; outputs hold their last values, except bitti=0.
- BINIS with basla=1 (active cycle):
  - Evaluate gates in index order 0..KAPI-1.
  - Gate i with o_yolcu=1 and g_kimlik=1 is admitted if seats remain. Gates with lower index win the last seats.
  - Gate i with o_yolcu=1 and g_kimlik=0 increments reddedilen, saturating.
  - Valid passengers refused because the aircraft is full are neither admitted nor counted as rejected.
  - o_yolcu=0 means no action, regardless of g_kimlik.
  - binen increases by at most min(admit requests, KAPASITE-binen) per cycle.
  - The timer increments by 1.
- BINIS with basla=0: pause. No admissions, no rejections, timer holds, state holds.
- End of boarding: evaluated on the edge of an active cycle. The window ends if the post-update binen == KAPASITE, or the post-update timer == SURE. Boarding therefore lasts at most SURE active cycles.
  - If post-update binen >= MIN_YOLCU, go to KALKIS; otherwise go to IPTAL.
- KALKIS: kalkis=1, bitti=1. IPTAL: kalkis=0, bitti=1. Both assert from the first cycle in the state.
- Leaving a done state: in KALKIS or IPTAL, basla=0 returns to BEKLE. bitti drops to 0; kalkis, binen and reddedilen hold. basla=1 keeps the done state (no auto-restart).
- New session: a new session starts only through BEKLE with basla=1; that transition clears kalkis.
- dolu is combinational from binen.
- Latency: inputs sampled on edge k are reflected in binen/reddedilen after edge k. A terminating active cycle shows bitti=1 after the same edge.

Test Plan:
- Reset mid-session: basla=1, both gates valid for 5 cycles (binen=10), then reset=1 for 1 cycle → kalkis=0, bitti=0, binen=0, reddedilen=0, state BEKLE.
- Fast fill: KAPI=2, basla=1, o_yolcu=2'b11, g_kimlik=2'b11 continuously → binen=40 and dolu=1 after 20 active cycles. On that same edge kalkis=1, bitti=1.
- All invalid IDs: o_yolcu=2'b11, g_kimlik=2'b00 for 50 active cycles → reddedilen=100, binen=0, bitti=1, kalkis=0 (IPTAL).
- Last-seat contention: reach binen=39, then one cycle with both gates valid → binen=40, gate 0 admitted, gate 1 neither admitted nor counted in reddedilen, KALKIS next.
- Pause, then threshold: gate 0 valid only on alternate active cycles, with basla=0 for 10 cycles midway.
  - Timer holds during the pause.
  - After 50 active cycles binen=25, bitti=1, kalkis=1.
  - Rerun with 19 admits → bitti=1, kalkis=0.
- Done-state release and restart:
  - In KALKIS, basla=0 for 1 cycle → bitti=0 with kalkis=1 held.
  - basla=1 → BINIS, kalkis=0, binen=0.
  - Saturation check with RED_W=4: 20 rejections → reddedilen=15.
